// File: rtl/loader_pkg.sv
// Shared types and image-format constants for the program loader.
// An image is a count byte, 2*N word bytes (high byte first), then one XOR checksum byte.
package loader_pkg;

    localparam int unsigned HEADER_BYTES = 1;
    localparam int unsigned CHECK_BYTES  = 1;

    typedef enum logic [2:0] {
        StCount,
        StHi,
        StLo,
        StCheck,
        StDone,
        StError
    } load_state_e;

    // Total stream length for an image carrying n words.
    function automatic int unsigned image_bytes(input int unsigned n);
        return HEADER_BYTES + 2 * n + CHECK_BYTES;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a checksummed program image into instruction memory.
// The CPU is held in reset until the whole image has been written and the checksum matches.
`ifndef INST_SIZE
`define INST_SIZE 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned INST_SIZE = `INST_SIZE,
    parameter int unsigned ADDR_SIZE = `ADDR_SIZE,
    parameter int unsigned BYTE_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [INST_SIZE-1:0] mem_data,
    output logic                 cpu_rst,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_SIZE-1:0] words_loaded
);

    load_state_e          state;
    logic [ADDR_SIZE-1:0] index;
    logic [BYTE_SIZE-1:0] xor_acc;
    logic [BYTE_SIZE-1:0] remaining;
    logic [BYTE_SIZE-1:0] hi_byte;
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StCount;
            in_ready     <= 1'b1;
            cpu_rst      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            index        <= '0;
            xor_acc      <= '0;
            remaining    <= '0;
            hi_byte      <= '0;
        end else begin
            // Write strobe is a single-cycle pulse following each low-byte acceptance.
            mem_we <= 1'b0;
            unique case (state)
                StCount: begin
                    if (accept) begin
                        xor_acc   <= in_data;
                        remaining <= in_data;
                        state     <= (in_data == '0) ? StCheck : StHi;
                    end
                end
                StHi: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        xor_acc <= xor_acc ^ in_data;
                        state   <= StLo;
                    end
                end
                StLo: begin
                    if (accept) begin
                        xor_acc      <= xor_acc ^ in_data;
                        mem_we       <= 1'b1;
                        mem_addr     <= index;
                        mem_data     <= {hi_byte, in_data};
                        index        <= index + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        remaining    <= remaining - 1'b1;
                        state        <= (remaining == BYTE_SIZE'(1)) ? StCheck : StHi;
                    end
                end
                StCheck: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == xor_acc) begin
                            state     <= StDone;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            state      <= StError;
                            load_error <= 1'b1;
                        end
                    end
                end
                StDone, StError: begin
                    if (start) begin
                        state        <= StCount;
                        in_ready     <= 1'b1;
                        cpu_rst      <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        index        <= '0;
                        words_loaded <= '0;
                        xor_acc      <= '0;
                        remaining    <= '0;
                    end
                end
                default: begin
                    state    <= StCount;
                    in_ready <= 1'b1;
                    cpu_rst  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as images are streamed
// and popped as the DUT pulses mem_we.
module tb_program_loader;
    import loader_pkg::*;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [7:0]  words_loaded;

    wr_t         exp_q[$];
    logic [7:0]  img[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          hold_guard = 1'b0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {24'd0, mem_addr}, 32'hffff_ffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                check("wr_data", {16'd0, mem_data}, {16'd0, e.data});
            end
        end
        if (hold_guard) check("cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gaps;
        int tries;
        gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'hxx;
            @(negedge clk);
            if (in_ready !== 1'b1) check("gap_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (in_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic queue_writes();
        wr_t w;
        for (int i = 0; i < int'(img[0]); i++) begin
            w.addr = 8'(i);
            w.data = {img[1 + 2 * i], img[2 + 2 * i]};
            exp_q.push_back(w);
        end
    endtask

    task automatic run_image(input int max_gap, input bit exp_ok, input int exp_words);
        int budget;
        queue_writes();
        for (int i = 0; i < img.size(); i++) begin
            if (i == img.size() - 1) hold_guard = 1'b0;
            send_byte(img[i], max_gap);
        end
        budget = 0;
        while (!(load_done || load_error) && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("load_done", {31'd0, load_done}, {31'd0, exp_ok});
        check("load_error", {31'd0, load_error}, {31'd0, !exp_ok});
        check("cpu_rst", {31'd0, cpu_rst}, {31'd0, !exp_ok});
        check("in_ready_end", {31'd0, in_ready}, 32'd0);
        check("words_loaded", {24'd0, words_loaded}, 32'(exp_words));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("image_len", 32'(img.size()), image_bytes(img[0]));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("start_done", {31'd0, load_done}, 32'd0);
        check("start_error", {31'd0, load_error}, 32'd0);
        check("start_ready", {31'd0, in_ready}, 32'd1);
        check("start_words", {24'd0, words_loaded}, 32'd0);
    endtask

    task automatic set_good();
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {16'd0, mem_data}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_error", {31'd0, load_error}, 32'd0);
        check("rst_words", {24'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good image, back-to-back.
        set_good();
        run_image(0, 1'b1, 2);

        // Stream ignored while DONE; start ignored when not DONE/ERROR is exercised below.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("done_hold", {31'd0, load_done}, 32'd1);
        check("done_ready", {31'd0, in_ready}, 32'd0);

        // Bad checksum.
        do_start();
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_image(0, 1'b0, 2);
        repeat (2) @(negedge clk);
        check("error_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Empty image.
        do_start();
        img = '{8'h00, 8'h00};
        run_image(0, 1'b1, 0);

        // Backpressure with random gaps; a stray start mid-load must be ignored.
        do_start();
        set_good();
        queue_writes();
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], 3);
            if (i == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_ignored", {31'd0, in_ready}, 32'd1);
            end
        end
        repeat (2) @(negedge clk);
        check("bp_done", {31'd0, load_done}, 32'd1);
        check("bp_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("bp_words", {24'd0, words_loaded}, 32'd2);
        check("bp_pending", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after the third byte, then a full reload.
        do_start();
        hold_guard = 1'b1;
        set_good();
        queue_writes();
        void'(exp_q.pop_back());
        for (int i = 0; i < 3; i++) send_byte(img[i], 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_cpu", {31'd0, cpu_rst}, 32'd1);
        check("mid_rst_words", {24'd0, words_loaded}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        run_image(1, 1'b1, 2);

        // Reload with a one-word image.
        do_start();
        img = '{8'h01, 8'h00, 8'h01, 8'h00};
        run_image(0, 1'b1, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of instruction memory. Receives a program image as a valid/ready byte stream and assembles it into INST_SIZE-bit instruction words.
- Writes the words into the instruction memory through its write port.
- Holds the CPU in reset until the full image is loaded and its checksum verifies; on a checksum mismatch the CPU stays in reset.
- Sits between the host/UART byte source and the cpu's instruction memory and reset input.

Parameters:
- INST_SIZE, 16, instruction width in bits; must equal 2*BYTE_SIZE.
- ADDR_SIZE, 8, instruction memory address width.
- BYTE_SIZE, 8, stream byte width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  BYTE_SIZE  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- start  input  1  one-cycle pulse requesting a reload; honoured only in DONE or ERROR
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  ADDR_SIZE  write address
- mem_data  output  INST_SIZE  write data
- cpu_rst  output  1  reset to the cpu; high while loading or in error
- load_done  output  1  image loaded and verified
- load_error  output  1  checksum mismatch
- words_loaded  output  ADDR_SIZE  number of words written in the current load

Behaviour:
- Image format:
  - count byte N (0..255);
  - N words, each sent high byte first;
  - one checksum byte equal to the XOR of the count byte and all 2N word bytes.
- Byte accepted when in_valid && in_ready on a rising edge.
- All outputs are registered. Reset values:
  - state=COUNT, in_ready=1, cpu_rst=1;
  - mem_we=0, mem_addr=0, mem_data=0;
  - load_done=0, load_error=0, words_loaded=0;
  - internal index, running XOR and remaining-count are cleared.
- rst is asynchronous: asserting it mid-load aborts immediately to the reset values. Words already written stay in memory.
- States and transitions:
  - COUNT: accept N, xor=N. Go to CHECK if N==0, else HI.
  - HI: accept byte, latch hi, xor^=byte. Go to LO.
  - LO: accept byte, xor^=byte. Next cycle: mem_we=1, mem_addr=index, mem_data={hi,byte}, index++, words_loaded++. Go to CHECK if this was word N, else HI.
  - CHECK: accept byte.
    - If byte==xor: DONE. load_done=1 and cpu_rst=0 in the following cycle.
    - Else: ERROR. load_error=1 in the following cycle; cpu_rst stays 1.
  - DONE / ERROR: in_ready=0; stream is ignored.
    - start=1: next cycle go to COUNT with cpu_rst=1, load_done=0, load_error=0, index=0, words_loaded=0.
- in_ready is 1 in COUNT, HI, LO and CHECK. The write pipeline never stalls the stream, so the loader can accept one byte per cycle with no bubbles.
- in_valid gaps are allowed in any state; state holds while no byte is accepted.
- Ordering guarantee: a word's write lands at least one cycle before cpu_rst can fall, because the write is issued the cycle after LO and the check byte cannot be accepted earlier than that same cycle.
- start in COUNT, HI, LO or CHECK is ignored. start coinciding with rst: rst wins.
- mem_addr never wraps, since N ≤ 255 < 2^ADDR_SIZE.
- mem_we is 0 in all cycles except the one following each LO acceptance.

Decomposition:
- Shared package loader_pkg: state enum (COUNT, HI, LO, CHECK, DONE, ERROR) and the image-format constant HEADER_BYTES=1.
- INST_SIZE and ADDR_SIZE defaults come from the existing config macros.
- No sub-module. The byte-to-word assembly is small enough to stay inline.

Test Plan:
- Good image: stream 02 12 34 AB CD 42 back-to-back → writes [0]=0x1234 and [1]=0xABCD on consecutive-pair cycles; load_done=1, cpu_rst=0, words_loaded=2.
- Bad checksum: same image but check byte 43 → both words written, load_error=1, cpu_rst stays 1, in_ready=0.
- Empty image: 00 00 → no mem_we pulses, load_done=1, words_loaded=0.
- Backpressure: good image from the first scenario with in_valid deasserted 0–3 random cycles between bytes → identical writes and result; state holds during gaps.
- Reset mid-load: rst pulse after the 3rd byte of the good image, then the full good image → cpu_rst stays 1 throughout; final load_done=1 and memory contains 0x1234, 0xABCD.
- Reload: after DONE, pulse start, then send 01 00 01 00 → cpu_rst=1 the cycle after start; [0]=0x0001; load_done=1, words_loaded=1.
